apb_master_bridge: RTL and testbench

Single-outstanding APB requester: converts a simple valid/ready command port into APB SETUP/ACCESS transfers on the same `apb_if` bus that `apb_slave_ip` responds on. Returns read data or write completion as a one-cycle response pulse. Becomes the bus driver in place of the testbench program, so system-level benches can issue register traffic through RTL.

---
 rtl/apb_master_bridge.sv | 165 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB requester driven by a valid/ready command port
//
// Converts one command at a time into an APB SETUP/ACCESS transfer and returns
// a one-cycle response pulse carrying read data (or 0 for writes).
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : ACCESS is aborted after TIMEOUT_CYCLES wait cycles, rsp_err=1
//   undefined : ACCESS waits for PREADY indefinitely, rsp_err is constant 0
//
// Ports:
//   PCLK, PRESET                 clock, synchronous active-high reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid, rsp_rdata, rsp_err    one-cycle completion pulse (no backpressure)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB requester outputs
//   PRDATA, PREADY               APB completer inputs
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Last wait count value before abort: the abort edge is the one at which
    // the count would reach TIMEOUT_CYCLES.
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic                    w_accept;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_psel_nxt;
    logic                    w_penable_nxt;
    logic                    w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rdata_nxt;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0]              r_wait_cnt;
    logic                    r_rsp_err;

    assign w_timeout = (r_state == ST_ACCESS) && !PREADY && (r_wait_cnt == LP_TO_LAST);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_wait_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_err <= w_timeout;
            if (r_state == ST_SETUP)
                r_wait_cnt <= '0;
            else if ((r_state == ST_ACCESS) && !PREADY)
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic                    w_unused_cfg;

    assign w_unused_cfg = ^LP_TO_LAST;
    assign w_timeout    = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_done   = (r_state == ST_ACCESS) && PREADY;

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (cmd_valid) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (PREADY || w_timeout) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Output decode: next values for the registered outputs
    always_comb begin
        w_psel_nxt      = (w_next != ST_IDLE);
        w_penable_nxt   = (w_next == ST_ACCESS);
        w_rsp_valid_nxt = w_done || w_timeout;
        w_rdata_nxt     = r_rsp_rdata;
        if (w_done)
            w_rdata_nxt = r_pwrite ? '0 : PRDATA;
        else if (w_timeout)
            w_rdata_nxt = '0;
    end

    // Registered outputs; bus address/data/direction hold their last value in IDLE
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rdata_nxt;
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end
        end
    end

    // Gated by PRESET so no command is offered during the reset cycle
    assign cmd_ready = (r_state == ST_IDLE) && !PRESET;

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int n_cmp = 0;
    int n_err = 0;
    int n_rsp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    apb_master_bridge #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h0;
        PREADY    = 1'b1;
        PRDATA    = 32'h0;

        @(negedge PCLK);
        chk("rst_psel",    PSEL,      1'b0);
        chk("rst_penable", PENABLE,   1'b0);
        chk("rst_pwrite",  PWRITE,    1'b0);
        chk("rst_paddr",   PADDR,     8'h00);
        chk("rst_pwdata",  PWDATA,    32'h0);
        chk("rst_rspv",    rsp_valid, 1'b0);
        chk("rst_rsperr",  rsp_err,   1'b0);
        chk("rst_rdata",   rsp_rdata, 32'h0);
        chk("rst_ready",   cmd_ready, 1'b0);
        PRESET = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'h0;
        chk("wr_setup_psel",    PSEL,      1'b1);
        chk("wr_setup_penable", PENABLE,   1'b0);
        chk("wr_setup_pwrite",  PWRITE,    1'b1);
        chk("wr_setup_paddr",   PADDR,     8'h10);
        chk("wr_setup_pwdata",  PWDATA,    32'hDEADBEEF);
        chk("wr_setup_ready",   cmd_ready, 1'b0);
        @(negedge PCLK);
        chk("wr_acc_psel",    PSEL,      1'b1);
        chk("wr_acc_penable", PENABLE,   1'b1);
        chk("wr_acc_rspv",    rsp_valid, 1'b0);
        @(negedge PCLK);
        chk("wr_rspv",     rsp_valid, 1'b1);
        chk("wr_rdata",    rsp_rdata, 32'h0);
        chk("wr_err",      rsp_err,   1'b0);
        chk("wr_end_psel", PSEL,      1'b0);
        chk("wr_end_pen",  PENABLE,   1'b0);
        chk("wr_end_rdy",  cmd_ready, 1'b1);
        @(negedge PCLK);
        chk("wr_pulse_end",     rsp_valid, 1'b0);
        chk("idle_hold_paddr",  PADDR,     8'h10);
        chk("idle_hold_pwdata", PWDATA,    32'hDEADBEEF);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; PRDATA = 32'h0BADF00D;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("rd_setup_pwrite", PWRITE, 1'b0);
        chk("rd_setup_paddr",  PADDR,  8'h10);
        @(negedge PCLK);
        PRDATA = 32'hDEADBEEF;
        chk("rd_acc_penable", PENABLE, 1'b1);
        @(negedge PCLK);
        PRDATA = 32'h0;
        chk("rd_rspv",  rsp_valid, 1'b1);
        chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge PCLK);
        chk("rd_pulse_end",  rsp_valid, 1'b0);
        chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h24; cmd_wdata = 32'hA5A55A5A;
        @(negedge PCLK);
        cmd_valid = 1'b0; cmd_addr = 8'h99; cmd_wdata = 32'h11111111; cmd_write = 1'b0;
        PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("ws_penable", PENABLE,   1'b1);
            chk("ws_paddr",   PADDR,     8'h24);
            chk("ws_pwdata",  PWDATA,    32'hA5A55A5A);
            chk("ws_pwrite",  PWRITE,    1'b1);
            chk("ws_rspv",    rsp_valid, 1'b0);
        end
        @(negedge PCLK);
        chk("ws_last_acc",  PENABLE,   1'b1);
        chk("ws_last_rspv", rsp_valid, 1'b0);
        PREADY = 1'b1;
        @(negedge PCLK);
        PRDATA = 32'h0;
        chk("ws_rspv",  rsp_valid, 1'b1);
        chk("ws_rdata", rsp_rdata, 32'h0);
        chk("ws_psel",  PSEL,      1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            chk("b2b_setup_psel", PSEL,    1'b1);
            chk("b2b_setup_pen",  PENABLE, 1'b0);
            chk("b2b_paddr",      PADDR,   8'(k));
            chk("b2b_pwdata",     PWDATA,  32'h100 + 32'(k));
            cmd_addr  = 8'(k + 1);
            cmd_wdata = 32'h100 + 32'(k + 1);
            if (k == 3) cmd_valid = 1'b0;
            @(negedge PCLK);
            chk("b2b_acc_psel",  PSEL,    1'b1);
            chk("b2b_acc_pen",   PENABLE, 1'b1);
            chk("b2b_acc_paddr", PADDR,   8'(k));
            @(negedge PCLK);
            n_rsp += int'(rsp_valid);
            chk("b2b_rdy",      cmd_ready, 1'b1);
            chk("b2b_psel_low", PSEL,      1'b0);
        end
        chk("b2b_rsp_count", n_rsp, 4);
        @(negedge PCLK);
        chk("b2b_no_extra", PSEL, 1'b0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mr_in_access", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mr_psel",  PSEL,      1'b0);
        chk("mr_pen",   PENABLE,   1'b0);
        chk("mr_rspv",  rsp_valid, 1'b0);
        chk("mr_ready", cmd_ready, 1'b0);
        PRESET = 1'b0; PREADY = 1'b1;
        #1;
        chk("mr_ready_after", cmd_ready, 1'b1);
        @(negedge PCLK);
        chk("mr_no_rsp",    rsp_valid, 1'b0);
        chk("mr_idle_psel", PSEL,      1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; PREADY = 1'b0; PRDATA = 32'h77;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("to_acc_pen",  PENABLE,   1'b1);
            chk("to_acc_rspv", rsp_valid, 1'b0);
        end
        @(negedge PCLK);
        chk("to_rspv",  rsp_valid, 1'b1);
        chk("to_err",   rsp_err,   1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_psel",  PSEL,      1'b0);
        chk("to_pen",   PENABLE,   1'b0);
        chk("to_ready", cmd_ready, 1'b1);
        @(negedge PCLK);
        chk("to_pulse_end", rsp_valid, 1'b0);
        chk("to_err_end",   rsp_err,   1'b0);
        PREADY = 1'b1; PRDATA = 32'h0;
`else
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            chk("hang_rspv", rsp_valid, 1'b0);
            chk("hang_acc",  (PSEL && PENABLE), 1'b1);
        end
        chk("hang_err", rsp_err, 1'b0);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0; PREADY = 1'b1;
        @(negedge PCLK);
        chk("hang_recover_psel", PSEL, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
